fb_port_arbiter: RTL and testbench
==================================

Name: fb_port_arbiter

Overview:
- Shares the single-port 256x256 RGB555 framebuffer BlockRam (16-bit address {col[7:0],row[7:0]}, 15-bit pixel) between three requesters: VGA scan-out reads, host pixel writes, and host pixel reads.
- Sits between the VGA top-level datapath, a host/drawing engine (GPIO-driven), and the BlockRam instance.
- Scan-out has absolute priority. Host traffic uses the remaining cycles, mainly blanking.
- Tracks in-flight reads so that each returning RAM word goes to the port that issued it.

Parameters:
- ADDR_W, 16, framebuffer address width.
- DATA_W, 15, pixel width (RGB555).
- RAM_LATENCY, 1, cycles from address presented to ram_q valid; legal range 1..3.

Ports:
- clock  in  1  system clock (CLOCK_50 domain)
- reset  in  1  asynchronous, active-high reset
- disp_req  in  1  scan-out read request this cycle (visible region)
- disp_addr  in  ADDR_W  scan-out address
- disp_pixel  out  DATA_W  scan-out read data
- disp_valid  out  1  disp_pixel valid strobe
- wr_valid  in  1  host write request
- wr_ready  out  1  host write accepted this cycle
- wr_addr  in  ADDR_W  host write address
- wr_data  in  DATA_W  host write pixel
- rd_valid  in  1  host read request
- rd_ready  out  1  host read accepted this cycle
- rd_addr  in  ADDR_W  host read address
- rd_data  out  DATA_W  host read data
- rd_data_valid  out  1  rd_data valid strobe
- ram_address  out  ADDR_W  to BlockRam address
- ram_data  out  DATA_W  to BlockRam data
- ram_wren  out  1  to BlockRam wren
- ram_q  in  DATA_W  from BlockRam q

Behaviour:
- Reset (async, active-high): rr_ptr=WRITE; tag pipeline cleared; disp_valid=0, rd_data_valid=0, disp_pixel=0, rd_data=0. While reset is held, wr_ready=0, rd_ready=0, ram_wren=0 and ram_address=0.
- Arbitration is evaluated every cycle and issues exactly one RAM operation or an idle cycle:
  - disp_req=1: grant DISP. ram_address=disp_addr, ram_wren=0, wr_ready=rd_ready=0.
  - Otherwise, if only wr_valid: grant WR. ram_address=wr_addr, ram_data=wr_data, ram_wren=1, wr_ready=1.
  - Otherwise, if only rd_valid: grant RD. ram_address=rd_addr, ram_wren=0, rd_ready=1.
  - wr_valid and rd_valid both set: grant goes to rr_ptr's port.
  - Otherwise: idle, ram_wren=0, ram_address holds its last value.
- wr_ready and rd_ready are combinational from the inputs and rr_ptr. A transfer completes on the clock edge where valid&ready=1.
- rr_ptr updates only on a host grant, flipping to the other host port. A DISP grant does not change rr_ptr.
- Host requesters must hold valid, addr and data stable until ready is seen. The arbiter never drops an accepted request.
- Tag pipeline: a RAM_LATENCY-deep shift register of 2-bit tags {NONE, DISP, RD}, loaded with the grant type each cycle (WR and idle load NONE).
  - When the tag reaches the output stage, ram_q is registered into disp_pixel or rd_data and the matching valid pulses for one cycle.
  - Total latency from grant to valid strobe is RAM_LATENCY+1 cycles.
  - Data registers hold their value when no strobe occurs.
- Reads are fully pipelined: one read may be issued per cycle.
- Ordering: a read issued the cycle after a write to the same address returns the new data.
- Continuous disp_req: host ports are starved indefinitely, by design. The VGA controller guarantees blanking windows.
- Reset mid-operation: in-flight tags are cleared, no stale valid strobes after reset releases, and unaccepted host requests are simply re-arbitrated.

Decomposition:
- Shared package fb_pkg:
  - FB_ADDR_W=16, FB_DATA_W=15.
  - Tag enum {TAG_NONE, TAG_DISP, TAG_RD}.
  - Helper constant for address packing {col[7:0],row[7:0]}.
- One sub-module: fb_tag_pipe (parameterised shift register plus output routing registers). The arbiter logic stays in the top.

Test Plan:
- RAM_LATENCY=1. disp_req=1, disp_addr=16'h0102 for one cycle; RAM model holds 15'h7C00 there -> disp_valid pulses exactly 2 cycles later with disp_pixel=15'h7C00, and wr_ready=rd_ready=0 during the grant.
- wr_valid=1, wr_addr=16'h00FF, wr_data=15'h03E0, disp_req=0 -> wr_ready=1, ram_wren=1 for one cycle. Next cycle rd of 16'h00FF is accepted and rd_data=15'h03E0 with rd_data_valid 2 cycles later.
- wr_valid and rd_valid both held for 6 cycles, disp_req=0 -> grants alternate WR,RD,WR,RD,WR,RD starting with WR after reset.
- disp_req held for 10 cycles while wr_valid=1 -> wr_ready=0 throughout. Write accepted the first cycle disp_req=0; wr_data unchanged in RAM model.
- Back-to-back mix DISP,RD,DISP,RD on addresses 0..3 -> strobes routed in the same order, each to the correct port, 2 cycles after issue, with no cross-delivery.
- Issue 3 reads (RAM_LATENCY=3), assert reset 1 cycle later -> no disp_valid/rd_data_valid strobes from those reads after reset deasserts. All outputs at reset values during reset.

Source files
------------

// File: rtl/fb_pkg.sv
// Shared definitions for the framebuffer port arbiter: bus widths,
// read-tag encoding, host round-robin pointer and grant types.
package fb_pkg;

  localparam int FB_ADDR_W = 16;
  localparam int FB_DATA_W = 15;

  // Framebuffer address is {col[7:0], row[7:0]}; the column sits above this bit.
  localparam int FB_COL_LSB = 8;

  // Identifies who a RAM read word belongs to as it travels down the tag pipe.
  typedef enum logic [1:0] {
    TAG_NONE = 2'd0,
    TAG_DISP = 2'd1,
    TAG_RD   = 2'd2
  } fb_tag_e;

  // Host port that wins when both host requesters are valid together.
  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } fb_rr_e;

  // RAM operation issued in the current cycle.
  typedef enum logic [1:0] {
    GNT_IDLE = 2'd0,
    GNT_DISP = 2'd1,
    GNT_WR   = 2'd2,
    GNT_RD   = 2'd3
  } fb_grant_e;

  function automatic logic [FB_ADDR_W-1:0] fb_pack_addr(input logic [7:0] col,
                                                        input logic [7:0] row);
    return {col, row};
  endfunction

endpackage

// File: rtl/fb_tag_pipe.sv
// Tracks which requester owns each in-flight RAM read and routes the
// returning word into the scan-out or host read data register.
module fb_tag_pipe
  import fb_pkg::*;
#(
  parameter int LATENCY = 1,
  parameter int DATA_W  = FB_DATA_W
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic [1:0]        i_tag,
  input  logic [DATA_W-1:0] i_ram_q,
  output logic [DATA_W-1:0] o_disp_pixel,
  output logic              o_disp_valid,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid
);

  logic [1:0]        r_tags [LATENCY];
  logic [1:0]        w_out_tag;
  logic [DATA_W-1:0] r_disp_pixel;
  logic              r_disp_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_rd_data_valid;

  // Shift the grant tag along so it lines up with ram_q for that address.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      for (int i = 0; i < LATENCY; i++) r_tags[i] <= TAG_NONE;
    end else begin
      r_tags[0] <= i_tag;
      for (int i = 1; i < LATENCY; i++) r_tags[i] <= r_tags[i-1];
    end
  end

  assign w_out_tag = r_tags[LATENCY-1];

  // Capture ram_q into the owning port; data registers hold between strobes.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      r_disp_pixel    <= '0;
      r_disp_valid    <= 1'b0;
      r_rd_data       <= '0;
      r_rd_data_valid <= 1'b0;
    end else begin
      r_disp_valid    <= (w_out_tag == TAG_DISP);
      r_rd_data_valid <= (w_out_tag == TAG_RD);
      if (w_out_tag == TAG_DISP) r_disp_pixel <= i_ram_q;
      if (w_out_tag == TAG_RD)   r_rd_data    <= i_ram_q;
    end
  end

  assign o_disp_pixel    = r_disp_pixel;
  assign o_disp_valid    = r_disp_valid;
  assign o_rd_data       = r_rd_data;
  assign o_rd_data_valid = r_rd_data_valid;

endmodule

// File: rtl/fb_port_arbiter.sv
// Single-port framebuffer RAM arbiter: scan-out reads always win, host
// writes and reads share the leftover cycles round-robin.
//
// rr_ptr   | meaning
// RR_WRITE | host write wins the next write/read tie
// RR_READ  | host read wins the next write/read tie
module fb_port_arbiter
  import fb_pkg::*;
#(
  parameter int ADDR_W      = FB_ADDR_W,
  parameter int DATA_W      = FB_DATA_W,
  parameter int RAM_LATENCY = 1
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_disp_req,
  input  logic [ADDR_W-1:0] i_disp_addr,
  output logic [DATA_W-1:0] o_disp_pixel,
  output logic              o_disp_valid,
  input  logic              i_wr_valid,
  output logic              o_wr_ready,
  input  logic [ADDR_W-1:0] i_wr_addr,
  input  logic [DATA_W-1:0] i_wr_data,
  input  logic              i_rd_valid,
  output logic              o_rd_ready,
  input  logic [ADDR_W-1:0] i_rd_addr,
  output logic [DATA_W-1:0] o_rd_data,
  output logic              o_rd_data_valid,
  output logic [ADDR_W-1:0] o_ram_address,
  output logic [DATA_W-1:0] o_ram_data,
  output logic              o_ram_wren,
  input  logic [DATA_W-1:0] i_ram_q
);

  fb_rr_e            r_rr;
  logic [ADDR_W-1:0] r_last_addr;
  fb_grant_e         w_grant;
  logic [ADDR_W-1:0] w_addr;
  logic [1:0]        w_tag;

  // Pick this cycle's RAM operation; nothing is granted while reset is held.
  always_comb begin
    w_grant = GNT_IDLE;
    if (!i_reset) begin
      if (i_disp_req)                    w_grant = GNT_DISP;
      else if (i_wr_valid && i_rd_valid) w_grant = (r_rr == RR_WRITE) ? GNT_WR : GNT_RD;
      else if (i_wr_valid)               w_grant = GNT_WR;
      else if (i_rd_valid)               w_grant = GNT_RD;
    end
  end

  // Address mux; an idle cycle keeps the previous address on the RAM.
  always_comb begin
    w_addr = r_last_addr;
    w_tag  = TAG_NONE;
    case (w_grant)
      GNT_DISP: begin w_addr = i_disp_addr; w_tag = TAG_DISP; end
      GNT_WR:   w_addr = i_wr_addr;
      GNT_RD:   begin w_addr = i_rd_addr;   w_tag = TAG_RD;   end
      default:  ;
    endcase
  end

  // Remember the last address driven so idle cycles do not toggle the bus.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                    r_last_addr <= '0;
    else if (w_grant != GNT_IDLE)   r_last_addr <= w_addr;
  end

  // Round-robin pointer flips only when a host port is served.
  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset)                  r_rr <= RR_WRITE;
    else if (w_grant == GNT_WR)   r_rr <= RR_READ;
    else if (w_grant == GNT_RD)   r_rr <= RR_WRITE;
  end

  assign o_wr_ready    = (w_grant == GNT_WR);
  assign o_rd_ready    = (w_grant == GNT_RD);
  assign o_ram_wren    = (w_grant == GNT_WR);
  assign o_ram_address = w_addr;
  assign o_ram_data    = i_wr_data;

  fb_tag_pipe #(
    .LATENCY (RAM_LATENCY),
    .DATA_W  (DATA_W)
  ) u_tag_pipe (
    .i_clock         (i_clock),
    .i_reset         (i_reset),
    .i_tag           (w_tag),
    .i_ram_q         (i_ram_q),
    .o_disp_pixel    (o_disp_pixel),
    .o_disp_valid    (o_disp_valid),
    .o_rd_data       (o_rd_data),
    .o_rd_data_valid (o_rd_data_valid)
  );

endmodule

// File: tb/tb_fb_port_arbiter.sv
// Bench for fb_port_arbiter: two instances (RAM latency 1 and 3) share one
// stimulus stream, each with its own RAM model; a transaction-level model
// predicts grants and read-return strobes and is compared every cycle.
module tb_fb_port_arbiter;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic        disp_req = 1'b0;
  logic [15:0] disp_addr = '0;
  logic        wr_valid = 1'b0;
  logic [15:0] wr_addr = '0;
  logic [14:0] wr_data = '0;
  logic        rd_valid = 1'b0;
  logic [15:0] rd_addr = '0;

  logic [14:0] disp_pixel [2];
  logic        disp_valid [2];
  logic        wr_ready [2];
  logic        rd_ready [2];
  logic [14:0] rd_data [2];
  logic        rd_data_valid [2];
  logic [15:0] ram_address [2];
  logic [14:0] ram_data [2];
  logic        ram_wren [2];
  logic [14:0] ram_q [2];

  fb_port_arbiter #(.RAM_LATENCY(1)) u_dut1 (
    .i_clock(clk), .i_reset(rst),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_pixel(disp_pixel[0]), .o_disp_valid(disp_valid[0]),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready[0]),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .o_rd_ready(rd_ready[0]), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data[0]), .o_rd_data_valid(rd_data_valid[0]),
    .o_ram_address(ram_address[0]), .o_ram_data(ram_data[0]),
    .o_ram_wren(ram_wren[0]), .i_ram_q(ram_q[0]));

  fb_port_arbiter #(.RAM_LATENCY(3)) u_dut3 (
    .i_clock(clk), .i_reset(rst),
    .i_disp_req(disp_req), .i_disp_addr(disp_addr),
    .o_disp_pixel(disp_pixel[1]), .o_disp_valid(disp_valid[1]),
    .i_wr_valid(wr_valid), .o_wr_ready(wr_ready[1]),
    .i_wr_addr(wr_addr), .i_wr_data(wr_data),
    .i_rd_valid(rd_valid), .o_rd_ready(rd_ready[1]), .i_rd_addr(rd_addr),
    .o_rd_data(rd_data[1]), .o_rd_data_valid(rd_data_valid[1]),
    .o_ram_address(ram_address[1]), .o_ram_data(ram_data[1]),
    .o_ram_wren(ram_wren[1]), .i_ram_q(ram_q[1]));

  // RAM models: synchronous write, read data after 1 or 3 cycles.
  logic [14:0] mem1 [65536];
  logic [14:0] mem3 [65536];
  logic [14:0] q1;
  logic [14:0] q3 [3];

  always @(posedge clk) begin
    if (ram_wren[0]) mem1[ram_address[0]] <= ram_data[0];
    q1 <= mem1[ram_address[0]];
  end
  assign ram_q[0] = q1;

  always @(posedge clk) begin
    if (ram_wren[1]) mem3[ram_address[1]] <= ram_data[1];
    q3[0] <= mem3[ram_address[1]];
    q3[1] <= q3[0];
    q3[2] <= q3[1];
  end
  assign ram_q[1] = q3[2];

  function automatic logic [14:0] init_val(int a);
    if (a == 16'h0102) return 15'h7C00;
    return 15'(a) ^ 15'h2A5A;
  endfunction

  int errs = 0;
  int checks = 0;
  logic chk_en = 1'b0;

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s actual=%h required=%h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // grant codes: 0 idle, 1 scan-out, 2 host write, 3 host read
  logic        m_next_wr;
  logic [15:0] m_last;
  int          cyc;
  logic [1:0]  s_kind [2][8];
  logic [14:0] s_data [2][8];
  logic        e_dv [2];
  logic        e_rv [2];
  logic [14:0] e_pix [2];
  logic [14:0] e_rd [2];
  logic [14:0] shadow [65536];

  function automatic int lat_of(int k);
    return (k == 0) ? 1 : 3;
  endfunction

  function automatic logic [1:0] m_grant();
    if (rst) return 2'd0;
    if (disp_req) return 2'd1;
    if (wr_valid && (!rd_valid || m_next_wr)) return 2'd2;
    if (rd_valid) return 2'd3;
    return 2'd0;
  endfunction

  function automatic logic [15:0] m_addr(logic [1:0] g);
    case (g)
      2'd1: return disp_addr;
      2'd2: return wr_addr;
      2'd3: return rd_addr;
      default: return m_last;
    endcase
  endfunction

  always @(posedge clk or posedge rst) begin : model
    logic [1:0]  g;
    logic [15:0] a;
    int n;
    int sl;
    int ts;
    if (rst) begin
      m_next_wr <= 1'b1;
      m_last    <= '0;
      cyc       <= 0;
      for (int k = 0; k < 2; k++) begin
        for (int s = 0; s < 8; s++) s_kind[k][s] <= 2'd0;
        e_dv[k]  <= 1'b0;
        e_rv[k]  <= 1'b0;
        e_pix[k] <= '0;
        e_rd[k]  <= '0;
      end
    end else begin
      g = m_grant();
      a = m_addr(g);
      n = cyc + 1;
      cyc <= n;
      for (int k = 0; k < 2; k++) begin
        sl = n % 8;
        e_dv[k] <= (s_kind[k][sl] == 2'd1);
        e_rv[k] <= (s_kind[k][sl] == 2'd2);
        if (s_kind[k][sl] == 2'd1) e_pix[k] <= s_data[k][sl];
        if (s_kind[k][sl] == 2'd2) e_rd[k]  <= s_data[k][sl];
        s_kind[k][sl] <= 2'd0;
        if (g == 2'd1 || g == 2'd3) begin
          ts = (n + lat_of(k)) % 8;
          s_kind[k][ts] <= (g == 2'd1) ? 2'd1 : 2'd2;
          s_data[k][ts] <= shadow[a];
        end
      end
      if (g == 2'd2) shadow[a] <= wr_data;
      if (g != 2'd0) m_last <= a;
      if (g == 2'd2) m_next_wr <= 1'b0;
      if (g == 2'd3) m_next_wr <= 1'b1;
    end
  end

  // Every-cycle comparison against the model, mid-cycle.
  always @(negedge clk) begin : compare
    logic [1:0]  g;
    logic [15:0] a;
    if (chk_en) begin
      g = m_grant();
      a = m_addr(g);
      for (int k = 0; k < 2; k++) begin
        chk($sformatf("L%0d wr_ready", lat_of(k)), 32'(wr_ready[k]), 32'(g == 2'd2));
        chk($sformatf("L%0d rd_ready", lat_of(k)), 32'(rd_ready[k]), 32'(g == 2'd3));
        chk($sformatf("L%0d ram_wren", lat_of(k)), 32'(ram_wren[k]), 32'(g == 2'd2));
        chk($sformatf("L%0d ram_address", lat_of(k)), 32'(ram_address[k]), 32'(a));
        if (g == 2'd2)
          chk($sformatf("L%0d ram_data", lat_of(k)), 32'(ram_data[k]), 32'(wr_data));
        chk($sformatf("L%0d disp_valid", lat_of(k)), 32'(disp_valid[k]), 32'(e_dv[k]));
        chk($sformatf("L%0d disp_pixel", lat_of(k)), 32'(disp_pixel[k]), 32'(e_pix[k]));
        chk($sformatf("L%0d rd_data_valid", lat_of(k)), 32'(rd_data_valid[k]), 32'(e_rv[k]));
        chk($sformatf("L%0d rd_data", lat_of(k)), 32'(rd_data[k]), 32'(e_rd[k]));
      end
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  logic [14:0] mix_tbl [4];

  initial begin
    for (int a = 0; a < 65536; a++) begin
      mem1[a]   = init_val(a);
      mem3[a]   = init_val(a);
      shadow[a] = init_val(a);
    end
    mix_tbl[0] = 15'h2A5A;
    mix_tbl[1] = 15'h2A5B;
    mix_tbl[2] = 15'h2A58;
    mix_tbl[3] = 15'h2A59;

    #1 rst = 1'b1;
    chk_en = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // scan-out read of 0x0102 beats both host requests
    disp_req = 1'b1; disp_addr = 16'h0102; wr_valid = 1'b1; rd_valid = 1'b1;
    #2;
    chk("disp grant wr_ready", 32'(wr_ready[0]), 32'd0);
    chk("disp grant rd_ready", 32'(rd_ready[0]), 32'd0);
    chk("disp grant address", 32'(ram_address[0]), 32'h0102);
    tick();
    disp_req = 1'b0; wr_valid = 1'b0; rd_valid = 1'b0;
    #2 chk("disp strobe early", 32'(disp_valid[0]), 32'd0);
    tick();
    #2;
    chk("disp strobe L1", 32'(disp_valid[0]), 32'd1);
    chk("disp pixel L1", 32'(disp_pixel[0]), 32'h7C00);
    tick(); tick();
    #2;
    chk("disp strobe L3", 32'(disp_valid[1]), 32'd1);
    chk("disp pixel L3", 32'(disp_pixel[1]), 32'h7C00);
    tick();

    // host write then read-back of the same address
    wr_valid = 1'b1; wr_addr = 16'h00FF; wr_data = 15'h03E0;
    #2;
    chk("wr accept", 32'(wr_ready[0]), 32'd1);
    chk("wr wren", 32'(ram_wren[0]), 32'd1);
    tick();
    wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 16'h00FF;
    #2 chk("rd accept", 32'(rd_ready[0]), 32'd1);
    tick();
    rd_valid = 1'b0;
    tick();
    #2;
    chk("rd back strobe", 32'(rd_data_valid[0]), 32'd1);
    chk("rd back data", 32'(rd_data[0]), 32'h03E0);
    repeat (4) tick();

    // both host ports held: grants alternate starting with the write
    wr_valid = 1'b1; wr_addr = 16'h0010; wr_data = 15'h1111;
    rd_valid = 1'b1; rd_addr = 16'h0020;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("alt wr_ready %0d", i), 32'(wr_ready[0]), 32'(i % 2 == 0));
      chk($sformatf("alt rd_ready %0d", i), 32'(rd_ready[0]), 32'(i % 2 == 1));
      tick();
    end
    wr_valid = 1'b0; rd_valid = 1'b0;
    repeat (4) tick();

    // scan-out holds off a pending write for 10 cycles
    wr_valid = 1'b1; wr_addr = 16'h0030; wr_data = 15'h5555;
    for (int i = 0; i < 10; i++) begin
      disp_req = 1'b1; disp_addr = 16'(i);
      #2 chk($sformatf("starve wr_ready %0d", i), 32'(wr_ready[0]), 32'd0);
      tick();
    end
    disp_req = 1'b0;
    #2 chk("starve release", 32'(wr_ready[0]), 32'd1);
    tick();
    wr_valid = 1'b0;
    #2 chk("starved write data", 32'(mem1[16'h0030]), 32'h5555);
    repeat (4) tick();

    // interleaved DISP,RD,DISP,RD on addresses 0..3
    for (int j = 0; j < 6; j++) begin
      disp_req = (j < 4) && (j % 2 == 0);
      rd_valid = (j < 4) && (j % 2 == 1);
      disp_addr = 16'(j);
      rd_addr   = 16'(j);
      #2;
      if (j >= 2) begin
        chk($sformatf("mix disp_valid %0d", j - 2), 32'(disp_valid[0]), 32'((j - 2) % 2 == 0));
        chk($sformatf("mix rd_valid %0d", j - 2), 32'(rd_data_valid[0]), 32'((j - 2) % 2 == 1));
        if ((j - 2) % 2 == 0)
          chk($sformatf("mix disp_pixel %0d", j - 2), 32'(disp_pixel[0]), 32'(mix_tbl[j-2]));
        else
          chk($sformatf("mix rd_data %0d", j - 2), 32'(rd_data[0]), 32'(mix_tbl[j-2]));
      end
      tick();
    end
    repeat (4) tick();

    // three reads in flight, then reset: nothing may come back afterwards
    rd_valid = 1'b1; rd_addr = 16'h0004; tick();
    rd_addr = 16'h0005; tick();
    rd_addr = 16'h0006; tick();
    rd_valid = 1'b0;
    rst = 1'b1; disp_req = 1'b1; disp_addr = 16'h1234; wr_valid = 1'b1;
    #2;
    chk("rst ram_address", 32'(ram_address[1]), 32'd0);
    chk("rst wr_ready", 32'(wr_ready[1]), 32'd0);
    chk("rst ram_wren", 32'(ram_wren[1]), 32'd0);
    chk("rst disp_valid", 32'(disp_valid[1]), 32'd0);
    chk("rst rd_data_valid", 32'(rd_data_valid[1]), 32'd0);
    chk("rst disp_pixel", 32'(disp_pixel[1]), 32'd0);
    chk("rst rd_data", 32'(rd_data[1]), 32'd0);
    tick(); tick();
    rst = 1'b0; disp_req = 1'b0; wr_valid = 1'b0;
    for (int i = 0; i < 6; i++) begin
      #2;
      chk($sformatf("post-rst rd_valid %0d", i), 32'(rd_data_valid[1]), 32'd0);
      chk($sformatf("post-rst disp_valid %0d", i), 32'(disp_valid[1]), 32'd0);
      tick();
    end
    repeat (2) tick();

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
